// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// sp_ram_fifo_ctrl_pkg: shared encodings and depth helper for the single-port RAM FIFO controller.
package sp_ram_fifo_ctrl_pkg;
    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_FETCH} op_e;
    typedef enum logic {PRIO_READ, PRIO_WRITE} prio_e;
    function automatic int unsigned depth(input int unsigned aw);
        return 2 ** aw;
    endfunction
endpackage

// File: rtl/sp_fifo_arbiter.sv
// sp_fifo_arbiter: grants one RAM op per cycle (write or fetch), alternating priority under contention.
module sp_fifo_arbiter
    import sp_ram_fifo_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic fetch_pending,
    input  logic wr_valid,
    input  logic ram_full,
    output logic wr_ready,
    output logic wr_grant,
    output logic rd_grant
);
    prio_e prio;
    assign wr_ready = !ram_full && !(fetch_pending && prio == PRIO_READ);
    assign wr_grant = wr_valid && wr_ready;
    assign rd_grant = fetch_pending && !wr_grant;
    // flip to the side that lost, so both sides progress every 2 cycles
    always_ff @(posedge clk or posedge reset)
        if (reset) prio <= PRIO_READ;
        else if (fetch_pending && wr_valid && !ram_full) prio <= wr_grant ? PRIO_READ : PRIO_WRITE;
endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: FIFO controller driving a single-port async-read RAM with a one-entry output register.
// Define SP_FIFO_BYPASS_EN to let a word skip the RAM when the FIFO is empty (1-cycle latency).
module sp_ram_fifo_ctrl
    import sp_ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = depth(ADDR_WIDTH);
    logic [PW-1:0] w_ptr, r_ptr, used;
    logic ram_empty, ram_full, fetch_pending, wr_grant, rd_grant, bypass;
    op_e op;
    assign used = w_ptr - r_ptr;
    assign ram_empty = used == '0;
    assign ram_full = used == PW'(DEPTH);
    assign fetch_pending = !ram_empty && (!rd_valid || rd_ready);
    sp_fifo_arbiter u_arb (
        .clk(clk),
        .reset(reset),
        .fetch_pending(fetch_pending),
        .wr_valid(wr_valid),
        .ram_full(ram_full),
        .wr_ready(wr_ready),
        .wr_grant(wr_grant),
        .rd_grant(rd_grant)
    );
`ifdef SP_FIFO_BYPASS_EN
    // empty FIFO with a free output register: the word goes straight to rd_data
    assign bypass = ram_empty && (!rd_valid || rd_ready) && wr_valid;
`else
    assign bypass = 1'b0;
`endif
    assign op = (wr_grant && !bypass) ? OP_WRITE : rd_grant ? OP_FETCH : OP_IDLE;
    assign ram_we = op == OP_WRITE;
    assign ram_addr = ram_we ? w_ptr[ADDR_WIDTH-1:0] : r_ptr[ADDR_WIDTH-1:0];
    assign ram_din = wr_data;
    assign count = used + PW'(rd_valid);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            if (op == OP_WRITE) w_ptr <= w_ptr + 1'b1;
            if (op == OP_FETCH) begin
                r_ptr <= r_ptr + 1'b1;
                rd_data <= ram_dout;
                rd_valid <= 1'b1;
            end else if (bypass) begin
                rd_data <= wr_data;
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) rd_valid <= 1'b0;
        end
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// tb_sp_ram_fifo_ctrl: directed scoreboard bench for sp_ram_fifo_ctrl at ADDR_WIDTH=2 with a behavioural RAM.
// Expectations adapt when SP_FIFO_BYPASS_EN is defined.
module tb_sp_ram_fifo_ctrl;
    logic clk = 0, reset = 1, wr_valid = 0, rd_ready = 0;
    logic wr_ready, rd_valid, ram_we;
    logic [7:0] wr_data = 0, rd_data, ram_din, ram_dout;
    logic [1:0] ram_addr;
    logic [2:0] count;
    logic [7:0] mem [4];
    logic [7:0] q [$];
    logic [7:0] next_val = 0;
    int total = 0, bad = 0, n_acc = 0;
    logic we_s;

    sp_ram_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic acc_w, acc_r;
        logic [7:0] rdat, exp_d;
        #1;
        acc_w = wr_valid && wr_ready;
        acc_r = rd_valid && rd_ready;
        rdat = rd_data;
        we_s = ram_we;
        @(posedge clk);
        #1;
        if (acc_w) begin
            q.push_back(wr_data);
            n_acc++;
            next_val++;
        end
        wr_data = next_val;
        if (acc_r) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                exp_d = q.pop_front();
                chk("sb_data", rdat, exp_d);
            end
        end
    endtask

    task automatic do_reset();
        wr_valid = 0;
        rd_ready = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        q.delete();
        #1;
    endtask

    task automatic drain();
        wr_valid = 0;
        rd_ready = 1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cyc();
        chk("drain_empty", q.size(), 0);
        chk("drain_rd_valid", rd_valid, 0);
        chk("drain_count", count, 0);
    endtask

    task automatic fill();
        rd_ready = 0;
        wr_valid = 1;
        for (int i = 0; i < 20 && q.size() < 5; i++) cyc();
        chk("fill_size", q.size(), 5);
    endtask

    initial begin
        int wcnt, alt;
        logic prev;
        do_reset();
        // reset in the middle of traffic
        wr_valid = 1;
        repeat (3) cyc();
        do_reset();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_wr_ready", wr_ready, 1);

        // single word
        next_val = 8'hA5;
        wr_data = next_val;
        wr_valid = 1;
        #1;
`ifdef SP_FIFO_BYPASS_EN
        chk("single_we", ram_we, 0);
`else
        chk("single_we", ram_we, 1);
        chk("single_addr", ram_addr, 0);
`endif
        cyc();
        wr_valid = 0;
        #1;
        chk("single_count1", count, 1);
`ifndef SP_FIFO_BYPASS_EN
        chk("single_lat1", rd_valid, 0);
        cyc();
`endif
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 8'hA5);
        chk("single_count", count, 1);
        drain();

        // fill to capacity, then drain in order
        do_reset();
        next_val = 0;
        wr_data = 0;
        fill();
        chk("full_count", count, 5);
        chk("full_wr_ready", wr_ready, 0);
        cyc();
        chk("full_hold", count, 5);
        chk("full_next", next_val, 5);
        drain();

        // contention: strict write/fetch alternation
        do_reset();
        rd_ready = 0;
        wr_valid = 1;
        for (int i = 0; i < 20 && q.size() < 3; i++) cyc();
        chk("cont_pre", q.size(), 3);
        rd_ready = 1;
        wcnt = 0;
        alt = 0;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            wcnt += int'(we_s);
            if (i > 0 && we_s == prev) alt++;
            prev = we_s;
        end
        chk("cont_writes", wcnt, 10);
        chk("cont_alternate", alt, 0);
        drain();

        // random traffic across pointer wrap
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 600 && (n_acc < 12 || q.size() > 0); i++) begin
            wr_valid = (n_acc < 12) && ($urandom_range(0, 1) == 1);
            rd_ready = $urandom_range(0, 1) == 1;
            cyc();
            chk("wrap_count", count, q.size());
            chk("wrap_max", count <= 5, 1);
            #1;
            if (q.size() == 5) chk("wrap_full_ready", wr_ready, 0);
            if (q.size() == 0) chk("wrap_empty_valid", rd_valid, 0);
        end
        chk("wrap_sent", n_acc, 12);
        chk("wrap_left", q.size(), 0);

        // asynchronous reset while full
        do_reset();
        fill();
        #2 reset = 1;
        #1;
        chk("async_rd_valid", rd_valid, 0);
        chk("async_count", count, 0);
        @(posedge clk);
        #1 reset = 0;
        q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
